// File: rtl/prog_loader.sv
// Serial program loader: 8N1 UART receiver feeding a framed, checksummed
// loader that writes program memory and holds the CPU in reset while loading.
module prog_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int MEM_DEPTH    = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] DEPTH8 = 8'(MEM_DEPTH);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_CNT, L_DATA, L_CSUM, L_ERR} ld_state_t;

    rx_state_t   rstate;
    ld_state_t   lstate;
    logic        rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] bcnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        byte_valid, frame_err;
    logic [7:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]  sum;
    logic        last;

    assign last = (8'(addr) + 8'd1) == cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rstate     <= R_IDLE;
            bcnt       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rstate <= R_START;
                        bcnt   <= '0;
                    end
                end
                R_START: begin
                    if (bcnt == HALF) begin
                        // a start bit that is high again by mid-bit was noise
                        bcnt    <= '0;
                        bit_idx <= '0;
                        rstate  <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (bcnt == FULL) begin
                        bcnt    <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rstate <= R_STOP;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (bcnt == FULL) begin
                        bcnt       <= '0;
                        byte_valid <= rx_s2;
                        frame_err  <= !rx_s2;
                        rstate     <= R_IDLE;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lstate   <= L_IDLE;
            cnt      <= '0;
            addr     <= '0;
            sum      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (lstate)
                L_IDLE: begin
                    if (byte_valid && shreg == SYNC) begin
                        lstate   <= L_CNT;
                        cpu_hold <= 1'b1;
                    end
                end
                L_CNT: begin
                    if (frame_err) begin
                        lstate <= L_ERR;
                        err    <= 1'b1;
                    end else if (byte_valid) begin
                        if (shreg == 8'd0 || shreg > DEPTH8) begin
                            lstate <= L_ERR;
                            err    <= 1'b1;
                        end else begin
                            cnt    <= shreg;
                            addr   <= '0;
                            sum    <= '0;
                            lstate <= L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (frame_err) begin
                        lstate <= L_ERR;
                        err    <= 1'b1;
                    end else if (byte_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= shreg;
                        sum     <= sum + shreg;
                        if (last) lstate <= L_CSUM;
                        else addr <= addr + 1'b1;
                    end
                end
                L_CSUM: begin
                    if (frame_err) begin
                        lstate <= L_ERR;
                        err    <= 1'b1;
                    end else if (byte_valid) begin
                        if (shreg == sum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            lstate   <= L_IDLE;
                        end else begin
                            lstate <= L_ERR;
                            err    <= 1'b1;
                        end
                    end
                end
                L_ERR: begin
                    // CPU stays held; only a fresh sync byte restarts a load
                    if (byte_valid && shreg == SYNC) begin
                        err    <= 1'b0;
                        lstate <= L_CNT;
                    end
                end
                default: lstate <= L_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: vector table, hand-written corner sequences and
// randomized frames checked against a byte-level frame model.
module tb_prog_loader;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       done;
    logic       err;

    prog_loader #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int wr_total = 0;
    int done_total = 0;
    logic [7:0] mem_tb [16];

    always @(negedge clk) begin
        if (wr_en) begin
            mem_tb[wr_addr] = wr_data;
            wr_total++;
        end
        if (done) done_total++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    typedef struct {
        int               len;
        logic [0:11][7:0] b;
        int               bad;
        int               n_wr;
        int               n_done;
        logic             e_err;
        logic             e_hold;
        logic [3:0]       l_addr;
        logic [7:0]       l_data;
    } vec_t;

    vec_t vt [8];

    initial begin
        int w0, d0, n;
        logic [7:0] d [16];
        logic [7:0] g;
        int s;
        logic [7:0] cs;
        bit good, ok;

        vt[0] = '{6, {48'hA50311223366, 48'h0}, -1, 3, 1, 1'b0, 1'b0, 4'd2, 8'h33};
        vt[1] = '{4, {32'hA5011011, 64'h0}, -1, 1, 0, 1'b1, 1'b1, 4'd0, 8'h10};
        vt[2] = '{2, {16'hA500, 80'h0}, -1, 0, 0, 1'b1, 1'b1, 4'd0, 8'h00};
        vt[3] = '{2, {16'hA511, 80'h0}, -1, 0, 0, 1'b1, 1'b1, 4'd0, 8'h00};
        vt[4] = '{4, {32'hA502AA55, 64'h0}, 3, 1, 0, 1'b1, 1'b1, 4'd0, 8'hAA};
        vt[5] = '{3, {24'h00FF5A, 72'h0}, -1, 0, 0, 1'b0, 1'b0, 4'd0, 8'h00};
        vt[6] = '{8, {64'hA5011011A5011010, 32'h0}, -1, 2, 1, 1'b0, 1'b0, 4'd0, 8'h10};
        vt[7] = '{5, {40'hA502FF0201, 56'h0}, -1, 2, 1, 1'b0, 1'b0, 4'd1, 8'h02};

        do_reset();
        @(negedge clk);
        chk("reset_outputs", {wr_en, wr_addr, wr_data, cpu_hold, done, err}, 32'h0);

        for (int k = 0; k < 8; k++) begin
            do_reset();
            w0 = wr_total;
            d0 = done_total;
            for (int j = 0; j < vt[k].len; j++) send_byte(vt[k].b[j], j != vt[k].bad);
            settle();
            chk($sformatf("v%0d_writes", k), wr_total - w0, vt[k].n_wr);
            chk($sformatf("v%0d_done", k), done_total - d0, vt[k].n_done);
            chk($sformatf("v%0d_err", k), err, vt[k].e_err);
            chk($sformatf("v%0d_hold", k), cpu_hold, vt[k].e_hold);
            chk($sformatf("v%0d_addr", k), wr_addr, vt[k].l_addr);
            chk($sformatf("v%0d_data", k), wr_data, vt[k].l_data);
        end

        // hold must rise on the sync byte and fall with done
        do_reset();
        w0 = wr_total;
        d0 = done_total;
        send_byte(8'hA5, 1'b1);
        settle();
        chk("hold_after_sync", cpu_hold, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        settle();
        chk("hold_before_cs", {cpu_hold, err}, 2'b10);
        chk("no_done_before_cs", done_total - d0, 0);
        send_byte(8'h66, 1'b1);
        settle();
        chk("hold_after_done", cpu_hold, 1'b0);
        chk("frame1_mem", {mem_tb[0], mem_tb[1], mem_tb[2]}, 24'h112233);

        // glitch in idle, then a normal frame
        do_reset();
        w0 = wr_total;
        d0 = done_total;
        @(posedge clk);
        rx = 1'b0;
        @(posedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        settle();
        chk("glitch_no_write", wr_total - w0, 0);
        chk("glitch_no_hold", {cpu_hold, err}, 2'b00);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        settle();
        chk("glitch_then_frame", {wr_total - w0, done_total - d0}, {32'd2, 32'd1});

        // async reset in the middle of a 16-byte load
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset", {wr_en, wr_addr, wr_data, cpu_hold, done, err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        w0 = wr_total;
        d0 = done_total;
        s = 0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'hC0 + 8'(i), 1'b1);
            s += 'hC0 + i;
        end
        send_byte(8'(s & 255), 1'b1);
        settle();
        chk("full16_writes", wr_total - w0, 16);
        chk("full16_done", done_total - d0, 1);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) if (mem_tb[i] !== 8'hC0 + 8'(i)) ok = 1'b0;
        chk("full16_mem", ok, 1'b1);

        // randomized frames against the byte-level model
        do_reset();
        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(1, 16);
            good = ($urandom_range(0, 3) != 0);
            s = 0;
            for (int i = 0; i < n; i++) begin
                d[i] = 8'($urandom_range(0, 255));
                s += int'(d[i]);
            end
            cs = 8'(s % 256);
            if (!good) cs = cs ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 2) == 0) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, 1'b1);
            end
            w0 = wr_total;
            d0 = done_total;
            send_byte(8'hA5, 1'b1);
            send_byte(8'(n), 1'b1);
            for (int i = 0; i < n; i++) send_byte(d[i], 1'b1);
            send_byte(cs, 1'b1);
            settle();
            chk($sformatf("rnd%0d_writes", f), wr_total - w0, n);
            chk($sformatf("rnd%0d_done", f), done_total - d0, good ? 1 : 0);
            chk($sformatf("rnd%0d_flags", f), {err, cpu_hold}, good ? 2'b00 : 2'b11);
            ok = 1'b1;
            for (int i = 0; i < n; i++) if (mem_tb[i] !== d[i]) ok = 1'b0;
            chk($sformatf("rnd%0d_mem", f), ok, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
